// File: rtl/xgmii_err_sched_if.sv
// Bus bundle between the XGMII loopback error scheduler and its environment:
// TX control lanes and configuration in, strobe, status and statistics out.
interface xgmii_err_sched_if #(
    parameter int CNT_W = 64
);
    logic [7:0]       xgmii_txc;
    logic             cfg_load;
    logic [1:0]       cfg_mode;
    logic [15:0]      cfg_period;
    logic [7:0]       cfg_burst;
    logic [15:0]      cfg_thresh;
    logic [15:0]      cfg_seed;
    logic             corrupt_strobe;
    logic             in_frame;
    logic             cfg_pending;
    logic [CNT_W-1:0] pkts_detected;
    logic [CNT_W-1:0] corrupted_pkts;
    logic [CNT_W-1:0] short_pkts;

    modport master (
        output xgmii_txc, cfg_load, cfg_mode, cfg_period, cfg_burst, cfg_thresh, cfg_seed,
        input  corrupt_strobe, in_frame, cfg_pending, pkts_detected, corrupted_pkts, short_pkts
    );

    modport slave (
        input  xgmii_txc, cfg_load, cfg_mode, cfg_period, cfg_burst, cfg_thresh, cfg_seed,
        output corrupt_strobe, in_frame, cfg_pending, pkts_detected, corrupted_pkts, short_pkts
    );
endinterface

// File: rtl/xgmii_err_sched.sv
// XGMII loopback error scheduler. Tracks frame boundaries on the TX control
// lanes, decides per frame (off / periodic / pseudo-random / burst) whether the
// frame is corrupted, and pulses corrupt_strobe on beat OFFSET of chosen frames.
// Every output is registered from the current txc sample, so all outputs lag
// xgmii_txc by exactly one cycle; the injector delays its data path to match.
module xgmii_err_sched #(
    parameter int          OFFSET    = 3,
    parameter int          CNT_W     = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    xgmii_err_sched_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam logic [7:0]       OFFSET_B = 8'(OFFSET);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t state_q, state_d;

    // Frame tracking and strobe
    logic             in_frame_q, in_frame_d;
    logic             strobe_q, strobe_d;
    logic [7:0]       beat_q, beat_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;

    // Decision state
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      ic_q, ic_d;
    logic [7:0]       bc_q, bc_d;

    // Active configuration
    logic [1:0]       mode_q, mode_d;
    logic [15:0]      period_q, period_d;
    logic [7:0]       burst_q, burst_d;
    logic [15:0]      thresh_q, thresh_d;

    // Deferred configuration
    logic             pending_q, pending_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic [15:0]      sh_period_q, sh_period_d;
    logic [7:0]       sh_burst_q, sh_burst_d;
    logic [15:0]      sh_thresh_q, sh_thresh_d;
    logic [15:0]      sh_seed_q, sh_seed_d;

    // Statistics
    logic [CNT_W-1:0] pkts_q, pkts_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] short_q, short_d;

    // Frame boundary events seen on this cycle's txc sample
    logic start_ev;
    logic end_ev;
    assign start_ev = (state_q == IDLE)  && (bus.xgmii_txc != 8'hFF);
    assign end_ev   = (state_q == FRAME) && (bus.xgmii_txc != 8'h00);

    // Interval wrap point: a period of 0 behaves as 1
    logic [15:0] p_last;
    logic        ic_wrap;
    logic [7:0]  bc_load;
    assign p_last  = ((period_q == 16'd0) ? 16'd1 : period_q) - 16'd1;
    assign ic_wrap = (ic_q == p_last);
    assign bc_load = ic_wrap ? burst_q : bc_q;

    // A load arriving this cycle takes precedence over the shadow copy
    logic [1:0]  ld_mode;
    logic [15:0] ld_period;
    logic [7:0]  ld_burst;
    logic [15:0] ld_thresh;
    logic [15:0] ld_seed;
    logic        apply_cfg;
    assign ld_mode   = bus.cfg_load ? bus.cfg_mode   : sh_mode_q;
    assign ld_period = bus.cfg_load ? bus.cfg_period : sh_period_q;
    assign ld_burst  = bus.cfg_load ? bus.cfg_burst  : sh_burst_q;
    assign ld_thresh = bus.cfg_load ? bus.cfg_thresh : sh_thresh_q;
    assign ld_seed   = bus.cfg_load ? bus.cfg_seed   : sh_seed_q;
    assign apply_cfg = ((state_q == IDLE) && !start_ev && bus.cfg_load) ||
                       (end_ev && (pending_q || bus.cfg_load));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter FRAME on any non-idle lane pattern, leave on any control lane
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ev) state_d = FRAME;
            FRAME:   if (end_ev)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: per-frame decision, beat tracking, strobe, statistics, config
    always_comb begin
        in_frame_d  = in_frame_q;
        strobe_d    = 1'b0;
        beat_d      = beat_q;
        sel_d       = sel_q;
        done_d      = done_q;
        lfsr_d      = lfsr_q;
        ic_d        = ic_q;
        bc_d        = bc_q;
        mode_d      = mode_q;
        period_d    = period_q;
        burst_d     = burst_q;
        thresh_d    = thresh_q;
        pending_d   = pending_q;
        sh_mode_d   = sh_mode_q;
        sh_period_d = sh_period_q;
        sh_burst_d  = sh_burst_q;
        sh_thresh_d = sh_thresh_q;
        sh_seed_d   = sh_seed_q;
        pkts_d      = pkts_q;
        corr_d      = corr_q;
        short_d     = short_q;

        if (start_ev) begin
            in_frame_d = 1'b1;
            beat_d     = 8'd1;
            done_d     = 1'b0;
            sel_d      = 1'b0;
            unique case (mode_q)
                2'd1: begin
                    sel_d = ic_wrap;
                    ic_d  = ic_wrap ? 16'd0 : ic_q + 16'd1;
                end
                2'd2: begin
                    sel_d  = (lfsr_q < thresh_q);
                    lfsr_d = lfsr_step(lfsr_q);
                end
                2'd3: begin
                    ic_d  = ic_wrap ? 16'd0 : ic_q + 16'd1;
                    sel_d = (bc_load != 8'd0);
                    bc_d  = (bc_load != 8'd0) ? bc_load - 8'd1 : bc_load;
                end
                default: sel_d = 1'b0;
            endcase
        end else if (state_q == FRAME) begin
            if (beat_q != 8'hFF) begin
                beat_d = beat_q + 8'd1;
            end
            if (sel_q && !done_q && (beat_q == OFFSET_B)) begin
                strobe_d = 1'b1;
                done_d   = 1'b1;
                corr_d   = corr_q + CNT_ONE;
            end
            if (end_ev) begin
                pkts_d = pkts_q + CNT_ONE;
                if (sel_q && !done_q && (beat_q != OFFSET_B)) begin
                    short_d = short_q + CNT_ONE;
                end
            end
        end else begin
            in_frame_d = 1'b0;
        end

        // Loads during a frame (or on its start beat) are parked in the shadow
        if (bus.cfg_load) begin
            sh_mode_d   = bus.cfg_mode;
            sh_period_d = bus.cfg_period;
            sh_burst_d  = bus.cfg_burst;
            sh_thresh_d = bus.cfg_thresh;
            sh_seed_d   = bus.cfg_seed;
        end
        if (end_ev) begin
            pending_d = 1'b0;
        end else if (bus.cfg_load && ((state_q == FRAME) || start_ev)) begin
            pending_d = 1'b1;
        end

        if (apply_cfg) begin
            mode_d   = ld_mode;
            period_d = ld_period;
            burst_d  = ld_burst;
            thresh_d = ld_thresh;
            lfsr_d   = (ld_seed == 16'd0) ? LFSR_SEED : ld_seed;
            ic_d     = 16'd0;
            bc_d     = 8'd0;
        end
    end

    // Control, decision and statistics registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_frame_q <= 1'b0;
            strobe_q   <= 1'b0;
            beat_q     <= 8'd0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            ic_q       <= 16'd0;
            bc_q       <= 8'd0;
            mode_q     <= 2'd0;
            period_q   <= 16'd1;
            burst_q    <= 8'd0;
            thresh_q   <= 16'd0;
            pending_q  <= 1'b0;
            pkts_q     <= '0;
            corr_q     <= '0;
            short_q    <= '0;
        end else begin
            in_frame_q <= in_frame_d;
            strobe_q   <= strobe_d;
            beat_q     <= beat_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            lfsr_q     <= lfsr_d;
            ic_q       <= ic_d;
            bc_q       <= bc_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            burst_q    <= burst_d;
            thresh_q   <= thresh_d;
            pending_q  <= pending_d;
            pkts_q     <= pkts_d;
            corr_q     <= corr_d;
            short_q    <= short_d;
        end
    end

    // Shadow config is only consumed while pending is set, so it needs no reset
    always_ff @(posedge clk) begin
        sh_mode_q   <= sh_mode_d;
        sh_period_q <= sh_period_d;
        sh_burst_q  <= sh_burst_d;
        sh_thresh_q <= sh_thresh_d;
        sh_seed_q   <= sh_seed_d;
    end

    assign bus.corrupt_strobe = strobe_q;
    assign bus.in_frame       = in_frame_q;
    assign bus.cfg_pending    = pending_q;
    assign bus.pkts_detected  = pkts_q;
    assign bus.corrupted_pkts = corr_q;
    assign bus.short_pkts     = short_q;

endmodule

// File: tb/tb_xgmii_err_sched.sv
// Randomized bench for xgmii_err_sched with a frame-level reference model.
module tb_xgmii_err_sched;

    localparam int OFFSET = 3;
    localparam int CNT_W  = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    xgmii_err_sched_if #(.CNT_W(CNT_W)) bus();

    xgmii_err_sched #(
        .OFFSET   (OFFSET),
        .CNT_W    (CNT_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] start_tbl [2] = '{8'h01, 8'h1F};
    logic [7:0] term_tbl  [8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    // Reference model: decision rules expressed per frame index since the last config load
    int          m_mode;
    int          m_period;
    int          m_burst;
    logic [15:0] m_thresh;
    logic [15:0] m_lfsr;
    int          m_n;
    logic [63:0] m_pkts, m_corr, m_short;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic m_cfg(input int mode, input int period, input int burst,
                         input logic [15:0] thresh, input logic [15:0] seed);
        m_mode   = mode;
        m_period = period;
        m_burst  = burst;
        m_thresh = thresh;
        m_lfsr   = (seed == 16'd0) ? 16'hACE1 : seed;
        m_n      = 0;
    endtask

    task automatic m_reset();
        m_cfg(0, 1, 0, 16'd0, 16'd0);
        m_pkts  = 0;
        m_corr  = 0;
        m_short = 0;
    endtask

    // Burst mode: only the latest wrap matters, since each wrap reloads the burst count
    task automatic m_start(output logic s);
        int p;
        int d;
        p = (m_period == 0) ? 1 : m_period;
        s = 1'b0;
        case (m_mode)
            1: s = ((m_n % p) == p - 1);
            2: begin
                s = (m_lfsr < m_thresh);
                m_lfsr = galois(m_lfsr);
            end
            3: if (m_n >= p - 1) begin
                d = (m_n - (p - 1)) % p;
                s = (d < m_burst);
            end
            default: s = 1'b0;
        endcase
        m_n++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_strobe"}, bus.corrupt_strobe, 1'b0);
        chk({tag, "_in_frame"}, bus.in_frame, 1'b0);
        chk({tag, "_pending"}, bus.cfg_pending, 1'b0);
        chk({tag, "_pkts"}, bus.pkts_detected, 64'd0);
        chk({tag, "_corr"}, bus.corrupted_pkts, 64'd0);
        chk({tag, "_short"}, bus.short_pkts, 64'd0);
    endtask

    task automatic cfg_idle(input logic [1:0] nm, input logic [15:0] np, input logic [7:0] nb,
                            input logic [15:0] nt, input logic [15:0] ns);
        bus.xgmii_txc  = 8'hFF;
        bus.cfg_load   = 1'b1;
        bus.cfg_mode   = nm;
        bus.cfg_period = np;
        bus.cfg_burst  = nb;
        bus.cfg_thresh = nt;
        bus.cfg_seed   = ns;
        tick();
        bus.cfg_load = 1'b0;
        m_cfg(int'(nm), int'(np), int'(nb), nt, ns);
        chk("cfg_idle_pending", bus.cfg_pending, 1'b0);
        chk("cfg_idle_in_frame", bus.in_frame, 1'b0);
    endtask

    // One frame of len beats (start, data, terminate), optional config load at cfg_beat
    task automatic send_frame(input int len, input int cfg_beat,
                              input logic [1:0] nm, input logic [15:0] np, input logic [7:0] nb,
                              input logic [15:0] nt, input logic [15:0] ns);
        logic s;
        logic pend;
        int   gap;
        pend = 1'b0;
        m_start(s);
        for (int b = 0; b < len; b++) begin
            if (b == 0)             bus.xgmii_txc = start_tbl[$urandom_range(0, 1)];
            else if (b == len - 1)  bus.xgmii_txc = term_tbl[$urandom_range(0, 7)];
            else                    bus.xgmii_txc = 8'h00;
            if (b == cfg_beat) begin
                bus.cfg_load   = 1'b1;
                bus.cfg_mode   = nm;
                bus.cfg_period = np;
                bus.cfg_burst  = nb;
                bus.cfg_thresh = nt;
                bus.cfg_seed   = ns;
            end
            tick();
            bus.cfg_load = 1'b0;
            if (b == cfg_beat) pend = 1'b1;
            chk("in_frame", bus.in_frame, 1'b1);
            chk("strobe", bus.corrupt_strobe, s && (b == OFFSET));
            if (b == len - 1) begin
                m_pkts++;
                if (s && (len - 1 >= OFFSET)) m_corr++;
                if (s && (len - 1 <  OFFSET)) m_short++;
                if (pend) m_cfg(int'(nm), int'(np), int'(nb), nt, ns);
                pend = 1'b0;
            end
            chk("pending", bus.cfg_pending, pend);
        end
        chk("pkts_detected", bus.pkts_detected, m_pkts);
        chk("corrupted_pkts", bus.corrupted_pkts, m_corr);
        chk("short_pkts", bus.short_pkts, m_short);
        gap = $urandom_range(1, 2);
        for (int g = 0; g < gap; g++) begin
            bus.xgmii_txc  = 8'hFF;
            bus.cfg_mode   = 2'($urandom);
            bus.cfg_period = 16'($urandom);
            bus.cfg_burst  = 8'($urandom);
            bus.cfg_thresh = 16'($urandom);
            bus.cfg_seed   = 16'($urandom);
            tick();
            chk("gap_in_frame", bus.in_frame, 1'b0);
            chk("gap_strobe", bus.corrupt_strobe, 1'b0);
        end
    endtask

    task automatic frames(input int count, input int lmin, input int lmax);
        for (int i = 0; i < count; i++) begin
            send_frame($urandom_range(lmin, lmax), -1, 2'd0, 16'd0, 8'd0, 16'd0, 16'd0);
        end
    endtask

    // Reset driven low at beat `at` of a frame aborts it with no side effects
    task automatic reset_mid_frame(input int at);
        for (int b = 0; b <= at; b++) begin
            bus.xgmii_txc = (b == 0) ? 8'h01 : 8'h00;
            if (b == at) reset = 1'b0;
            tick();
            if (b < at) chk("rst_pre_in_frame", bus.in_frame, 1'b1);
        end
        chk_zero("rst_mid");
        reset = 1'b1;
        bus.xgmii_txc = 8'hFF;
        tick();
        chk_zero("rst_after");
        m_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] c0, c1, c2;
        bus.xgmii_txc  = 8'hFF;
        bus.cfg_load   = 1'b0;
        bus.cfg_mode   = 2'd0;
        bus.cfg_period = 16'd0;
        bus.cfg_burst  = 8'd0;
        bus.cfg_thresh = 16'd0;
        bus.cfg_seed   = 16'd0;
        m_reset();

        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b1;
        tick();

        // Off: 10 frames of 8 beats
        c0 = bus.pkts_detected;
        frames(10, 8, 8);
        chk("m0_pkts_delta", bus.pkts_detected - c0, 64'd10);
        chk("m0_corr", bus.corrupted_pkts, 64'd0);

        // Periodic, every 4th frame
        cfg_idle(2'd1, 16'd4, 8'd0, 16'd0, 16'd0);
        c0 = bus.corrupted_pkts;
        frames(12, 8, 8);
        chk("m1_corr_delta", bus.corrupted_pkts - c0, 64'd3);

        // Burst of 2 every 5 frames
        cfg_idle(2'd3, 16'd5, 8'd2, 16'd0, 16'd0);
        c0 = bus.corrupted_pkts;
        frames(15, 8, 8);
        chk("m3_corr_delta", bus.corrupted_pkts - c0, 64'd5);

        // Short frames around OFFSET
        cfg_idle(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        c0 = bus.short_pkts;
        frames(4, 3, 3);
        chk("short_delta", bus.short_pkts - c0, 64'd4);
        c0 = bus.corrupted_pkts;
        frames(1, 4, 4);
        chk("end_at_offset_corr", bus.corrupted_pkts - c0, 64'd1);

        // Period 0 behaves as 1
        cfg_idle(2'd1, 16'd0, 8'd0, 16'd0, 16'd0);
        frames(3, 5, 6);

        // Random mode, 1000 frames
        cfg_idle(2'd2, 16'd1, 8'd0, 16'h8000, 16'h0001);
        c0 = bus.corrupted_pkts;
        frames(1000, 4, 5);
        chk("m2_model_total", bus.corrupted_pkts, m_corr);

        cfg_idle(2'd2, 16'd1, 8'd0, 16'h0000, 16'h0001);
        c0 = bus.corrupted_pkts;
        frames(50, 4, 6);
        chk("m2_thresh0", bus.corrupted_pkts - c0, 64'd0);

        cfg_idle(2'd2, 16'd1, 8'd0, 16'hFFFF, 16'd0);
        frames(20, 4, 6);

        cfg_idle(2'd2, 16'd1, 8'd0, 16'h8000, 16'h0001);
        c0 = bus.corrupted_pkts;
        frames(200, 6, 6);
        c1 = bus.corrupted_pkts - c0;
        cfg_idle(2'd2, 16'd1, 8'd0, 16'h8000, 16'h0001);
        c0 = bus.corrupted_pkts;
        frames(200, 6, 6);
        c2 = bus.corrupted_pkts - c0;
        chk("m2_repro", c2, c1);

        // Load to mode 0 at beat 2 of a selected frame
        cfg_idle(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        c0 = bus.corrupted_pkts;
        send_frame(8, 2, 2'd0, 16'd1, 8'd0, 16'd0, 16'd0);
        frames(3, 8, 8);
        chk("midload_corr_delta", bus.corrupted_pkts - c0, 64'd1);

        // Load coincident with frame start: old config used for that frame
        cfg_idle(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        c0 = bus.corrupted_pkts;
        send_frame(6, 0, 2'd0, 16'd1, 8'd0, 16'd0, 16'd0);
        frames(2, 6, 6);
        chk("startload_corr_delta", bus.corrupted_pkts - c0, 64'd1);

        // Randomized configurations and frames
        for (int i = 0; i < 150; i++) begin
            int len;
            len = $urandom_range(2, 12);
            if ($urandom_range(0, 9) == 0) begin
                cfg_idle(2'($urandom), 16'($urandom_range(0, 6)), 8'($urandom_range(0, 7)),
                         16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
            end
            if ($urandom_range(0, 7) == 0) begin
                send_frame(len, $urandom_range(0, len - 2), 2'($urandom),
                           16'($urandom_range(0, 6)), 8'($urandom_range(0, 7)),
                           16'($urandom), 16'($urandom));
            end else begin
                send_frame(len, -1, 2'd0, 16'd0, 8'd0, 16'd0, 16'd0);
            end
        end

        // Reset in the middle of a frame, then a clean frame
        cfg_idle(2'd1, 16'd1, 8'd0, 16'd0, 16'd0);
        reset_mid_frame(2);
        frames(1, 6, 6);
        chk("post_reset_pkts", bus.pkts_detected, 64'd1);
        chk("post_reset_corr", bus.corrupted_pkts, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgmii_err_sched.md
Name: xgmii_err_sched

Overview:
- Scheduler that decides which looped-back XGMII frames receive an injected channel error, and when.
- Replaces the static per-packet corruption table with runtime-configurable modes: off, periodic, pseudo-random and burst.
- Monitors the TX XGMII control lanes to find frame boundaries.
- Emits a single-cycle corrupt strobe, aligned to a chosen data beat, to the loopback injector; also keeps frame and corruption statistics.

Parameters:
- OFFSET, 3: beat index within a frame at which corrupt_strobe is high; the start beat is index 0; legal range 1..255.
- CNT_W, 64: width of the statistics counters.
- LFSR_SEED, 16'hACE1: LFSR value after reset and whenever cfg_seed == 0 is loaded.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- xgmii_txc  in  8  TX XGMII control lanes, sampled every cycle.
- cfg_load  in  1  one-cycle pulse requesting capture of the cfg_* inputs.
- cfg_mode  in  2  0 = off, 1 = periodic, 2 = random, 3 = burst.
- cfg_period  in  16  periodic/burst interval in frames; 0 is treated as 1.
- cfg_burst  in  8  number of consecutive frames corrupted per burst; 0 means none.
- cfg_thresh  in  16  random mode: corrupt when LFSR < cfg_thresh.
- cfg_seed  in  16  LFSR seed; 0 selects LFSR_SEED.
- corrupt_strobe  out  1  high for exactly one cycle, during beat OFFSET of a selected frame.
- in_frame  out  1  high from the start beat through the end beat.
- cfg_pending  out  1  a cfg_load has been accepted but not yet applied.
- pkts_detected  out  CNT_W  number of frames whose end has been seen.
- corrupted_pkts  out  CNT_W  number of corrupt_strobe pulses issued.
- short_pkts  out  CNT_W  frames selected for corruption that ended before beat OFFSET.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - All outputs go to 0. The FSM goes to IDLE.
  - Active config is cleared to mode 0, period 1, burst 0, thresh 0.
  - LFSR = LFSR_SEED; the frame-interval counter and burst counter are cleared.
  - Reset asserted mid-frame aborts the frame silently: no counter increments and no strobe.
- FSM states: IDLE, FRAME.
  - IDLE → FRAME when xgmii_txc != 8'hFF. This cycle is beat 0.
  - On that edge: the per-frame decision `sel` is computed and latched, the beat counter is set to 1, and in_frame is set to 1.
  - FRAME → IDLE when xgmii_txc != 8'h00 (any control lane set). This cycle is the end beat.
  - On that edge: pkts_detected increments; short_pkts increments if `sel` is set and the strobe was not yet issued; in_frame clears on the following edge.
  - A frame whose start beat also has txc != 0 (for example an FB in lane 4) still spends at least one cycle in FRAME.
- in_frame is registered and is high during every beat of the frame, including beat 0. It is set on the edge preceding beat 0 via a lookahead on the registered txc: the block internally delays its observation by one cycle, so all outputs lag xgmii_txc by exactly one cycle. The injector must apply the same 1-cycle delay to the data path.
- Beat counter: 8 bits, saturates at 255, and increments each FRAME cycle.
- corrupt_strobe: registered; high for the single cycle whose delayed beat index == OFFSET, provided `sel` is set. At most one pulse per frame.
  - If the end beat arrives at an index below OFFSET, no pulse is issued.
  - An end beat exactly at index OFFSET still pulses.
  - corrupted_pkts increments on the same edge that raises the strobe.
- Decision at frame start, by active mode:
  - Mode 0: sel = 0.
  - Mode 1: interval counter ic counts 0..P-1 and wraps, where P = max(cfg_period, 1). sel = (ic == P-1). ic advances once per frame.
  - Mode 2:
    - Galois LFSR, taps x^16+x^14+x^13+x^11+1, steps once per frame start.
    - The comparison uses the pre-step value: sel = (lfsr < cfg_thresh).
    - thresh 0 means never corrupt; thresh 16'hFFFF means every frame except lfsr == 16'hFFFF.
  - Mode 3:
    - When ic wraps (ic == P-1), the burst counter bc is loaded with cfg_burst.
    - sel = (bc != 0) evaluated after that load, and bc decrements when sel is set.
    - If the bursts overlap because cfg_burst ≥ P, bc is reloaded; this yields continuous corruption.
- Config:
  - cfg_load in IDLE applies on the same edge, and ic, bc and the LFSR are re-initialised.
  - cfg_load during FRAME sets cfg_pending. The cfg_* values are captured into a shadow register at pulse time, then applied on the FRAME → IDLE edge, where cfg_pending clears. The in-flight frame keeps its `sel`.
  - A second cfg_load while pending overwrites the shadow.
  - cfg_load coincident with frame start: the start edge wins, the load becomes pending, and the frame uses the old config.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Mode 0; 10 frames of 8 beats each (start, 6 data beats, terminate) → pkts_detected = 10, corrupted_pkts = 0, corrupt_strobe never high, in_frame high 8 cycles per frame.
- Mode 1, period 4, OFFSET 3; 12 frames → strobe in frames 4, 8 and 12 only, each exactly 1 cycle, at delayed beat 3; corrupted_pkts = 3.
- Mode 3, period 5, burst 2; 15 frames → frames 5, 6, 10, 11, 15 corrupted; corrupted_pkts = 5.
- Mode 1, period 1; frames of 3 beats (end at index 2) with OFFSET 3 → no strobe, short_pkts increments per frame; a 4-beat frame (end at index 3) → strobe issued.
- Mode 2, seed 16'h0001, thresh 16'h8000; 1000 frames → corrupted_pkts equals the golden LFSR model count exactly; thresh 0 → 0; reloading the same seed reproduces the identical sequence.
- cfg_load (mode 1→0) pulsed at beat 2 of a selected frame → strobe still issued for that frame, cfg_pending high until the end beat, no later strobes; reset driven low at beat 2 → all outputs 0 on the next cycle and no counter increments.
